// File: rtl/ram_responder.sv
// ram_responder: memory-side responder for the control unit's RAM bus.
// A boot loader fills the array from a valid/ready stream, then hands
// the bus to the control unit by raising cpu_enable.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   addressbus/read/write - control-unit bus (ignored while loading)
//   toram / fromram       - write data in / combinational read data out
//   load_valid/data/last  - loader stream, load_ready = accept this cycle
//   cpu_enable            - releases the control unit once loading ends
//   load_count            - words accepted since reset (saturates at depth)
//   bus_error             - sticky: read and write seen together in RUN
module ram_responder #(
  parameter int adlines   = 8,
  parameter int datalines = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [adlines-1:0]   addressbus,
  input  logic                 read,
  input  logic                 write,
  input  logic [datalines-1:0] toram,
  output logic [datalines-1:0] fromram,
  input  logic                 load_valid,
  input  logic [datalines-1:0] load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  output logic                 cpu_enable,
  output logic [adlines:0]     load_count,
  output logic                 bus_error
);

  typedef enum logic {LOAD, RUN} state_t;

  state_t               state;
  // One bit wider than the address so it can reach the full depth without
  // wrapping; it doubles as the accepted-word count.
  logic [adlines:0]     ptr;
  logic [datalines-1:0] mem [2**adlines];

  logic load_we, cpu_we;

  assign load_we    = (state == LOAD) && load_valid;
  // A read/write collision is a protocol error; the write is dropped.
  assign cpu_we     = (state == RUN) && write && !read;
  assign load_count = ptr;

  // Array is never cleared; reset only blocks writes on its edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (load_we)
        mem[ptr[adlines-1:0]] <= load_data;
      else if (cpu_we)
        mem[addressbus] <= toram;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      ptr        <= '0;
      load_ready <= 1'b1;
      cpu_enable <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (load_valid) begin
            ptr <= ptr + 1'b1;
            // Last address written means the array is full: leave now so
            // the pointer can never wrap onto word 0.
            if (load_last || (ptr[adlines-1:0] == '1)) begin
              state      <= RUN;
              load_ready <= 1'b0;
              cpu_enable <= 1'b1;
            end
          end
        end
        RUN: begin
          if (read && write)
            bus_error <= 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Zero-wait-state read: the control unit samples on the next edge.
  always_comb begin
    fromram = '0;
    if (state == RUN && read)
      fromram = mem[addressbus];
  end

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- DUT A: default geometry ----------------
  logic        a_reset = 1'b1, a_rd = 0, a_wr = 0, a_lv = 0, a_ll = 0;
  logic [7:0]  a_addr = 0;
  logic [15:0] a_to = 0, a_ld = 0, a_from;
  logic        a_lr, a_en, a_err;
  logic [8:0]  a_cnt;

  ram_responder #(.adlines(8), .datalines(16)) dut_a (
    .clk(clk), .reset(a_reset), .addressbus(a_addr), .read(a_rd), .write(a_wr),
    .toram(a_to), .fromram(a_from), .load_valid(a_lv), .load_data(a_ld),
    .load_last(a_ll), .load_ready(a_lr), .cpu_enable(a_en),
    .load_count(a_cnt), .bus_error(a_err));

  // ---------------- DUT B: 8-word array ----------------
  logic        b_reset = 1'b1, b_rd = 0, b_wr = 0, b_lv = 0, b_ll = 0;
  logic [2:0]  b_addr = 0;
  logic [15:0] b_to = 0, b_ld = 0, b_from;
  logic        b_lr, b_en, b_err;
  logic [3:0]  b_cnt;

  ram_responder #(.adlines(3), .datalines(16)) dut_b (
    .clk(clk), .reset(b_reset), .addressbus(b_addr), .read(b_rd), .write(b_wr),
    .toram(b_to), .fromram(b_from), .load_valid(b_lv), .load_data(b_ld),
    .load_last(b_ll), .load_ready(b_lr), .cpu_enable(b_en),
    .load_count(b_cnt), .bus_error(b_err));

  // ---------------- reference model for A ----------------
  logic [15:0] mref [256];
  bit          known [256];
  int          m_cnt;
  bit          m_run, m_err;

  // Apply the effect of one rising edge given the inputs now on the bus.
  task automatic model_edge();
    if (a_reset) begin
      m_run = 0; m_cnt = 0; m_err = 0;
    end else if (!m_run) begin
      if (a_lv) begin
        mref[m_cnt] = a_ld; known[m_cnt] = 1;
        m_cnt++;
        if (a_ll || m_cnt == 256) m_run = 1;
      end
    end else if (a_rd && a_wr) begin
      m_err = 1;
    end else if (a_wr) begin
      mref[a_addr] = a_to; known[a_addr] = 1;
    end
  endtask

  task automatic chk_regs_a(input string tag);
    chk({tag, ".ready"}, 32'(a_lr), 32'(!m_run));
    chk({tag, ".en"},    32'(a_en), 32'(m_run));
    chk({tag, ".cnt"},   32'(a_cnt), 32'(m_cnt));
    chk({tag, ".err"},   32'(a_err), 32'(m_err));
  endtask

  // One bus cycle on A: check the combinational read, clock, check state.
  task automatic cyc_a(input string tag);
    logic [15:0] e;
    #1;
    e = (m_run && a_rd) ? mref[a_addr] : 16'h0;
    chk({tag, ".rd"}, 32'(a_from), 32'(e));
    model_edge();
    @(posedge clk); #1;
    chk_regs_a(tag);
  endtask

  task automatic idle_a();
    a_rd = 0; a_wr = 0; a_lv = 0; a_ll = 0; a_reset = 0;
  endtask

  task automatic load_a(input logic [15:0] d, input logic last, input string tag);
    a_lv = 1; a_ld = d; a_ll = last;
    cyc_a(tag);
    a_lv = 0; a_ll = 0;
  endtask

  task automatic write_a(input logic [7:0] ad, input logic [15:0] d, input string tag);
    a_wr = 1; a_rd = 0; a_addr = ad; a_to = d;
    cyc_a(tag); cyc_a(tag);
    a_wr = 0;
  endtask

  task automatic read_a(input logic [7:0] ad, input string tag);
    a_rd = 1; a_addr = ad;
    cyc_a(tag);
    a_rd = 0;
  endtask

  task automatic reset_a();
    a_reset = 1; cyc_a("rst"); cyc_a("rst"); a_reset = 0;
  endtask

  initial begin
    int r;
    logic [7:0] ad;

    // Power-up: DUT state undefined until the first reset edge.
    a_reset = 1; b_reset = 1;
    @(posedge clk); @(posedge clk); #1;
    m_run = 0; m_cnt = 0; m_err = 0;
    chk_regs_a("reset");
    chk("b.reset.cnt", 32'(b_cnt), 0);
    chk("b.reset.ready", 32'(b_lr), 1);
    chk("b.reset.en", 32'(b_en), 0);

    // Gaps: valid 1,0,0,1 -> only two words accepted at 0 and 1.
    idle_a();
    a_rd = 1;  // reads during LOAD must return 0
    load_a(16'hAAAA, 0, "gap0");
    cyc_a("gap1"); cyc_a("gap2");
    load_a(16'hBBBB, 1, "gap3");
    a_rd = 0;
    read_a(0, "gap.rd0"); read_a(1, "gap.rd1");
    chk("gap.cnt", 32'(a_cnt), 2);

    // Boot: 0x11, 0x22, 0x33; a LOAD-time write to address 0 must be ignored.
    reset_a();
    load_a(16'h0011, 0, "boot0");
    load_a(16'h0022, 0, "boot1");
    a_wr = 1; a_addr = 0; a_to = 16'hDEAD;
    load_a(16'h0033, 1, "boot2");
    a_wr = 0;
    chk("boot.cnt", 32'(a_cnt), 3);
    chk("boot.en", 32'(a_en), 1);
    chk("boot.ready", 32'(a_lr), 0);
    read_a(0, "boot.rd0"); read_a(1, "boot.rd1"); read_a(2, "boot.rd2");

    // RUN write/read.
    write_a(5, 16'h1234, "w5");
    a_rd = 1; a_addr = 5; #1;
    chk("rd5", 32'(a_from), 32'h1234);
    a_rd = 0; #1;
    chk("rd5.off", 32'(a_from), 0);
    write_a(9, 16'hBEEF, "w9");
    read_a(9, "rd9");
    chk("rd9.err", 32'(a_err), 0);

    // Violation: write suppressed, read still served, error sticky.
    a_rd = 1; a_wr = 1; a_addr = 9; a_to = 16'h0000;
    cyc_a("viol");
    idle_a();
    cyc_a("viol.hold"); cyc_a("viol.hold");
    chk("viol.err", 32'(a_err), 1);
    read_a(9, "viol.rd9");

    // Randomized RUN traffic.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      ad = 8'($urandom);
      if (r < 4) begin
        write_a(ad, 16'($urandom), "rw");
      end else if (r < 9) begin
        for (int t = 0; t < 20 && !known[ad]; t++) ad = 8'($urandom);
        if (!known[ad]) ad = 0;
        if (r == 8) begin
          a_rd = 1; a_wr = 1; a_addr = ad; a_to = 16'($urandom);
          cyc_a("rviol");
          idle_a();
        end else begin
          read_a(ad, "rr");
        end
      end else begin
        cyc_a("ridle");
      end
    end

    // Reset in RUN with a write on the same edge: write dropped.
    a_reset = 1; a_wr = 1; a_addr = 5; a_to = 16'hFFFF;
    cyc_a("rstrun");
    idle_a();
    chk("rstrun.en", 32'(a_en), 0);
    chk("rstrun.err", 32'(a_err), 0);
    load_a(16'h5555, 1, "reboot");
    read_a(5, "rstrun.rd5");
    read_a(0, "reboot.rd0");

    // ---------------- DUT B: reset mid-load, then full array ----------------
    b_reset = 0;
    for (int i = 0; i < 2; i++) begin
      b_lv = 1; b_ld = 16'h0101 * 16'(i + 1);
      @(posedge clk); #1;
    end
    b_lv = 0;
    chk("b.mid.cnt", 32'(b_cnt), 2);
    b_reset = 1;
    @(posedge clk); #1;
    b_reset = 0;
    chk("b.rst.cnt", 32'(b_cnt), 0);
    chk("b.rst.en", 32'(b_en), 0);
    chk("b.rst.ready", 32'(b_lr), 1);
    for (int i = 0; i < 8; i++) begin
      b_lv = 1; b_ld = 16'h1000 + 16'(i);
      @(posedge clk); #1;
      chk("b.full.cnt", 32'(b_cnt), 32'(i + 1));
      chk("b.full.en", 32'(b_en), 32'(i == 7));
    end
    b_ld = 16'hFFFF;  // 9th word must be ignored
    @(posedge clk); #1;
    b_lv = 0;
    chk("b.ninth.cnt", 32'(b_cnt), 8);
    chk("b.ninth.ready", 32'(b_lr), 0);
    for (int i = 0; i < 8; i++) begin
      b_rd = 1; b_addr = 3'(i); #1;
      chk("b.rd", 32'(b_from), 32'h1000 + 32'(i));
    end
    b_rd = 0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
